// File: rtl/cache_pkg.sv
// Shared types and constants for the blocking direct-mapped write-back cache.
package cache_pkg;

    localparam int NUM_LINES      = 32;
    localparam int INDEX_BITS     = 5;
    localparam int WORDS_PER_LINE = 16;
    localparam int WORD_BITS      = 4;

    // Memory request type, shared with the datapath request mux
    localparam logic MEM_REQ_READ  = 1'b0;
    localparam logic MEM_REQ_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        TAG_CHECK,
        EVICT,
        REFILL,
        RESP,
        FLUSH
    } state_t;

endpackage

// File: rtl/cache_line_state.sv
// Per-line valid/dirty bits; cleared asynchronously, one set/clear port at idx_i.
module cache_line_state
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] idx_i,
    input  logic                  set_valid_i,
    input  logic                  set_dirty_i,
    input  logic                  clr_dirty_i,
    output logic                  valid_o,
    output logic                  dirty_o
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (set_valid_i) valid_d[idx_i] = 1'b1;
        if (set_dirty_i)      dirty_d[idx_i] = 1'b1;
        else if (clr_dirty_i) dirty_d[idx_i] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];

endmodule

// File: rtl/cache_base_ctrl.sv
// Control FSM for the direct-mapped write-back cache: tag check, evict, refill,
// processor response and whole-cache flush, with one mem transaction outstanding.
module cache_base_ctrl
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memreq_val,
    output logic                  memreq_rdy,
    output logic                  memresp_val,
    input  logic                  memresp_rdy,
    output logic                  cache_req_val,
    input  logic                  cache_req_rdy,
    output logic                  cache_req_wr,
    input  logic                  cache_resp_val,
    output logic                  cache_resp_rdy,
    input  logic                  flush_val,
    output logic                  flush_done,
    input  logic [INDEX_BITS-1:0] index,
    input  logic                  read,
    input  logic                  tag_array_match,
    output logic [INDEX_BITS-1:0] line_sel,
    output logic                  data_array_r_en,
    output logic                  data_array_w_en,
    output logic                  data_array_write_mux_sel,
    output logic                  tag_array_w_en,
    output logic [WORD_BITS-1:0]  received_mem_resp_num
);

    state_t                state_q, state_d;
    logic                  wait_q, wait_d;         // 1 = request accepted, awaiting mem resp
    logic [WORD_BITS-1:0]  cnt_q, cnt_d;
    logic                  flushing_q, flushing_d;
    logic [INDEX_BITS-1:0] fline_q, fline_d;
    logic                  started_q;              // holds memreq_rdy low until first edge out of reset

    logic line_valid, line_dirty;
    logic set_valid, set_dirty, clr_dirty;
    logic last_word;

    assign line_sel              = flushing_q ? fline_q : index;
    assign received_mem_resp_num = cnt_q;
    assign last_word             = (cnt_q == WORD_BITS'(WORDS_PER_LINE - 1));

    cache_line_state u_line_state (
        .clk         (clk),
        .rst_n       (reset),
        .idx_i       (line_sel),
        .set_valid_i (set_valid),
        .set_dirty_i (set_dirty),
        .clr_dirty_i (clr_dirty),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty)
    );

    always_comb begin
        state_d                  = state_q;
        wait_d                   = wait_q;
        cnt_d                    = cnt_q;
        flushing_d               = flushing_q;
        fline_d                  = fline_q;
        memreq_rdy               = 1'b0;
        memresp_val              = 1'b0;
        cache_req_val            = 1'b0;
        cache_req_wr             = MEM_REQ_READ;
        cache_resp_rdy           = 1'b0;
        flush_done               = 1'b0;
        data_array_r_en          = 1'b0;
        data_array_w_en          = 1'b0;
        data_array_write_mux_sel = 1'b0;
        tag_array_w_en           = 1'b0;
        set_valid                = 1'b0;
        set_dirty                = 1'b0;
        clr_dirty                = 1'b0;
        unique case (state_q)
            IDLE: begin
                memreq_rdy = started_q & ~flush_val;
                if (started_q && flush_val) begin
                    state_d    = FLUSH;
                    flushing_d = 1'b1;
                    fline_d    = '0;
                end else if (memreq_val && memreq_rdy) begin
                    state_d = TAG_CHECK;
                end
            end
            TAG_CHECK: begin
                data_array_r_en = 1'b1;
                cnt_d           = '0;
                wait_d          = 1'b0;
                if (line_valid && tag_array_match) begin
                    if (!read) begin
                        data_array_w_en = 1'b1;
                        set_dirty       = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    state_d = line_dirty ? EVICT : REFILL;
                end
            end
            EVICT, REFILL: begin
                // Eviction streams words out of the data array, so keep it read-enabled
                data_array_r_en = (state_q == EVICT);
                cache_req_wr    = (state_q == EVICT) ? MEM_REQ_WRITE : MEM_REQ_READ;
                if (!wait_q) begin
                    cache_req_val = 1'b1;
                    if (cache_req_rdy) wait_d = 1'b1;
                end else begin
                    cache_resp_rdy = 1'b1;
                    if (cache_resp_val) begin
                        wait_d = 1'b0;
                        cnt_d  = cnt_q + 1'b1;
                        if (state_q == REFILL) begin
                            data_array_w_en          = 1'b1;
                            data_array_write_mux_sel = 1'b1;
                        end
                        if (last_word) begin
                            clr_dirty = 1'b1;
                            if (state_q == EVICT) begin
                                state_d = flushing_q ? FLUSH : REFILL;
                            end else begin
                                tag_array_w_en = 1'b1;
                                set_valid      = 1'b1;
                                state_d        = TAG_CHECK;
                            end
                        end
                    end
                end
            end
            RESP: begin
                memresp_val = 1'b1;
                if (memresp_rdy) state_d = IDLE;
            end
            FLUSH: begin
                cnt_d  = '0;
                wait_d = 1'b0;
                // An evicted line comes back here clean and is then stepped past
                if (line_valid && line_dirty) begin
                    state_d = EVICT;
                end else if (fline_q == INDEX_BITS'(NUM_LINES - 1)) begin
                    flush_done = 1'b1;
                    flushing_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    fline_d = fline_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_q     <= 1'b0;
            cnt_q      <= '0;
            flushing_q <= 1'b0;
            fline_q    <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            cnt_q      <= cnt_d;
            flushing_q <= flushing_d;
            fline_q    <= fline_d;
            started_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_base_ctrl.sv
// Directed bench for cache_base_ctrl with a small tag-array and single-outstanding memory model.
module tb_cache_base_ctrl;
    import cache_pkg::*;

    logic clk, reset;
    logic memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic cache_req_val, cache_req_rdy, cache_req_wr, cache_resp_val, cache_resp_rdy;
    logic flush_val, flush_done, read, tag_array_match;
    logic [4:0] index, line_sel;
    logic data_array_r_en, data_array_w_en, data_array_write_mux_sel, tag_array_w_en;
    logic [3:0] received_mem_resp_num;

    logic [20:0] req_tag;
    logic [20:0] tag_mem [32];
    logic        pending;
    logic [3:0]  exp_off;
    int wr_reqs = 0, rd_reqs = 0, rd_at_wr = 0, off_err = 0, proto_err = 0;
    int pw_cnt = 0, mw_cnt = 0, tw_cnt = 0, fd_cnt = 0;
    int n_cmp = 0, n_err = 0;

    cache_base_ctrl dut (
        .clk(clk), .reset(reset),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .cache_req_val(cache_req_val), .cache_req_rdy(cache_req_rdy), .cache_req_wr(cache_req_wr),
        .cache_resp_val(cache_resp_val), .cache_resp_rdy(cache_resp_rdy),
        .flush_val(flush_val), .flush_done(flush_done),
        .index(index), .read(read), .tag_array_match(tag_array_match),
        .line_sel(line_sel), .data_array_r_en(data_array_r_en), .data_array_w_en(data_array_w_en),
        .data_array_write_mux_sel(data_array_write_mux_sel), .tag_array_w_en(tag_array_w_en),
        .received_mem_resp_num(received_mem_resp_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag array model: never cleared by reset, like the real SRAM
    always @(posedge clk) if (tag_array_w_en) tag_mem[index] <= req_tag;
    assign tag_array_match = (tag_mem[index] == req_tag);
    assign cache_resp_val  = pending;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            exp_off <= '0;
        end else begin
            if (cache_req_val && cache_req_rdy) begin
                if (pending) proto_err <= proto_err + 1;
                if (received_mem_resp_num != exp_off) off_err <= off_err + 1;
                if (cache_req_wr) begin
                    wr_reqs  <= wr_reqs + 1;
                    rd_at_wr <= rd_reqs;
                end else begin
                    rd_reqs <= rd_reqs + 1;
                end
                pending <= 1'b1;
            end else if (cache_resp_val && cache_resp_rdy) begin
                pending <= 1'b0;
                exp_off <= exp_off + 1'b1;
            end
            if (data_array_w_en && !data_array_write_mux_sel) pw_cnt <= pw_cnt + 1;
            if (data_array_w_en &&  data_array_write_mux_sel) mw_cnt <= mw_cnt + 1;
            if (tag_array_w_en) tw_cnt <= tw_cnt + 1;
            if (flush_done)     fd_cnt <= fd_cnt + 1;
        end
    end

    wire [13:0] outv = {memreq_rdy, memresp_val, cache_req_val, cache_req_wr, cache_resp_rdy,
                        flush_done, data_array_r_en, data_array_w_en, data_array_write_mux_sel,
                        tag_array_w_en, received_mem_resp_num};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_addr(input logic [31:0] addr, input bit wr);
        index   = addr[10:6];
        req_tag = addr[31:11];
        read    = !wr;
    endtask

    // Issue one request and return edges from fire to memresp_val
    task automatic access(input logic [31:0] addr, input bit wr, output int lat);
        int n;
        set_addr(addr, wr);
        memreq_val = 1'b1;
        n = 0;
        while (!memreq_rdy && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("req_rdy_timeout", 0, 1);
        @(negedge clk);
        memreq_val = 1'b0;
        lat = 1;
        while (!memresp_val && lat < 400) begin @(negedge clk); lat++; end
        if (memresp_rdy) @(negedge clk);
    endtask

    initial begin
        int lat, rd0, wr0, pw0, mw0, tw0, fd0, n, ok_val, ok_rdy;
        reset = 1'b0; memreq_val = 1'b0; memresp_rdy = 1'b1; cache_req_rdy = 1'b1;
        flush_val = 1'b0; index = '0; read = 1'b1; req_tag = '0;

        #2 chk("reset_outs", {18'd0, outv}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1 chk("rdy_before_edge", memreq_rdy, 0);
        @(negedge clk);
        chk("rdy_after_edge", memreq_rdy, 1);

        // 1: cold read miss, clean refill
        rd0 = rd_reqs; wr0 = wr_reqs; mw0 = mw_cnt; tw0 = tw_cnt;
        access(32'h0000_1000, 0, lat);
        chk("t1_lat", lat, 35);
        chk("t1_rd", rd_reqs - rd0, 16);
        chk("t1_wr", wr_reqs - wr0, 0);
        chk("t1_memw", mw_cnt - mw0, 16);
        chk("t1_tagw", tw_cnt - tw0, 1);
        chk("t1_offs", off_err, 0);

        // 2: read hit
        rd0 = rd_reqs;
        access(32'h0000_1004, 0, lat);
        chk("t2_lat", lat, 2);
        chk("t2_rd", rd_reqs - rd0, 0);

        // 3: write hit, then conflicting read forces eviction before refill
        pw0 = pw_cnt;
        access(32'h0000_1008, 1, lat);
        chk("t3_wlat", lat, 2);
        chk("t3_pw", pw_cnt - pw0, 1);
        rd0 = rd_reqs; wr0 = wr_reqs;
        access(32'h0000_1808, 0, lat);
        chk("t3_lat", lat, 67);
        chk("t3_wr", wr_reqs - wr0, 16);
        chk("t3_rd", rd_reqs - rd0, 16);
        chk("t3_order", rd_at_wr, rd0);
        chk("t3_offs", off_err, 0);

        // 4: response stall
        memresp_rdy = 1'b0;
        access(32'h0000_1808, 0, lat);
        chk("t4_lat", lat, 2);
        ok_val = 0; ok_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (memresp_val) ok_val++;
            if (!memreq_rdy) ok_rdy++;
        end
        chk("t4_val_held", ok_val, 5);
        chk("t4_rdy_low", ok_rdy, 5);
        memresp_rdy = 1'b1;
        @(negedge clk);
        chk("t4_idle", memreq_rdy, 1);

        // 5: dirty lines 3 and 31, then flush
        pw0 = pw_cnt;
        access(32'h0000_10C0, 1, lat);
        chk("t5_w3_lat", lat, 35);
        access(32'h0000_17C0, 1, lat);
        chk("t5_w31_lat", lat, 35);
        chk("t5_pw", pw_cnt - pw0, 2);
        rd0 = rd_reqs; wr0 = wr_reqs; fd0 = fd_cnt;
        set_addr(32'h0000_1140, 0);
        flush_val = 1'b1; memreq_val = 1'b1;
        #1 chk("t5_flush_prio", memreq_rdy, 0);
        @(negedge clk);
        flush_val = 1'b0; memreq_val = 1'b0;
        chk("t5_line_sel0", line_sel, 0);
        n = 0;
        while (fd_cnt == fd0 && n < 1000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("t5_done", fd_cnt - fd0, 1);
        chk("t5_wr", wr_reqs - wr0, 32);
        chk("t5_rd", rd_reqs - rd0, 0);
        rd0 = rd_reqs;
        access(32'h0000_10C0, 0, lat);
        chk("t5_hit_lat", lat, 2);
        chk("t5_hit_rd", rd_reqs - rd0, 0);

        // 6: reset during refill word 7
        set_addr(32'h0000_2000, 0);
        memreq_val = 1'b1;
        @(negedge clk);
        memreq_val = 1'b0;
        n = 0;
        while (!(cache_req_val && received_mem_resp_num == 4'd7) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("t6_reach_w7", (n < 200), 1);
        reset = 1'b0;
        #1 chk("t6_reset_outs", {18'd0, outv}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1 chk("t6_rdy_before_edge", memreq_rdy, 0);
        @(negedge clk);
        rd0 = rd_reqs;
        access(32'h0000_1808, 0, lat);
        chk("t6_miss_lat", lat, 35);
        chk("t6_miss_rd", rd_reqs - rd0, 16);
        chk("proto", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
